// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: branch redirect, imem request/response and decode-side instruction queue.
// master = fetch unit, slave = surrounding pipeline / instruction memory.
interface instr_fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, misalign_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC register + credit-based instruction fetch with a small in-order queue toward decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect target raises a sticky fault and halts fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IQ_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int             PTR_W   = $clog2(IQ_DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(IQ_DEPTH);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [1:0] ST_HALT  = 2'd2;
`endif

    logic [1:0]       state;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] q_cnt;
    logic [PTR_W-1:0] q_hd;
    logic [PTR_W-1:0] q_tl;
    logic [PTR_W-1:0] t_rd;
    logic [PTR_W-1:0] t_wr;
    logic [31:0]      q_data [IQ_DEPTH];
    logic [31:0]      q_pc   [IQ_DEPTH];
    logic [31:0]      tag_pc [IQ_DEPTH];

    logic             run;
    logic             redir;
    logic             credit;
    logic             req_valid;
    logic             accept;
    logic             rsp;
    logic             q_wr;
    logic             q_pop;
    logic [31:0]      target;
    logic [CNT_W-1:0] drop_next;

    assign run    = (state == ST_RUN);
    assign redir  = bus.redirect_valid;
    // Queue slots are reserved at request time so a response can never find the queue full.
    assign credit = ({1'b0, outstanding} + {1'b0, q_cnt}) < DEPTH_V;
    assign req_valid = run & credit & ~redir & ~rst;
    assign accept = req_valid & bus.imem_req_ready;
    // Responses with nothing outstanding belong to requests issued before a reset: ignore them.
    assign rsp    = bus.imem_rsp_valid & (outstanding != '0);
    assign q_wr   = run & rsp & ~redir;
    assign q_pop  = (q_cnt != '0) & bus.inst_ready & ~redir;
    assign drop_next = (run ? outstanding : drop_cnt) - CNT_W'(rsp);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign;
    logic fault;
    assign target   = bus.redirect_pc;
    assign misalign = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign target   = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN, ST_FLUSH: begin
                    if (redir) begin
                        fetch_pc    <= target;
                        outstanding <= outstanding - CNT_W'(rsp);
                        drop_cnt    <= drop_next;
                        state       <= (drop_next == '0) ? ST_RUN : ST_FLUSH;
`ifdef FETCH_ALIGN_CHECK_EN
                        if (misalign) begin
                            state <= ST_HALT;
                            fault <= 1'b1;
                        end
`endif
                    end else begin
                        outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp);
                        if (accept)
                            fetch_pc <= fetch_pc + 32'd4;
                        // In FLUSH every response is a stale one being drained.
                        if (!run && rsp) begin
                            drop_cnt <= drop_cnt - 1'b1;
                            if (drop_cnt == CNT_W'(1))
                                state <= ST_RUN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Instruction queue plus the PC-tag FIFO that pairs each in-order response with its request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_hd  <= '0;
            q_tl  <= '0;
            q_cnt <= '0;
            t_rd  <= '0;
            t_wr  <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
                tag_pc[i] <= '0;
            end
        end else if (redir) begin
            q_hd  <= '0;
            q_tl  <= '0;
            q_cnt <= '0;
            t_rd  <= '0;
            t_wr  <= '0;
        end else begin
            if (accept) begin
                tag_pc[t_wr] <= fetch_pc;
                t_wr         <= t_wr + 1'b1;
            end
            if (q_wr) begin
                q_data[q_tl] <= bus.imem_rsp_data;
                q_pc[q_tl]   <= tag_pc[t_rd];
                q_tl         <= q_tl + 1'b1;
                t_rd         <= t_rd + 1'b1;
            end
            if (q_pop)
                q_hd <= q_hd + 1'b1;
            q_cnt <= q_cnt + CNT_W'(q_wr) - CNT_W'(q_pop);
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (q_cnt != '0);
    assign bus.inst_data      = q_data[q_hd];
    assign bus.inst_pc        = q_pc[q_hd];
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.misalign_fault = fault;
`else
    assign bus.misalign_fault = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit against an instruction-stream reference model.
module tb_instr_fetch_unit;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IQ_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        mq[$];
    logic [31:0] acc_log[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          occ = 0;
    logic [31:0] exp_req_pc = 0;
    logic [31:0] exp_inst_pc = 0;
    bit          halted = 0;
    int          lat_max = 1;
    bit          rdy_rand = 0;
    int          ir_mode = 1;
    int          n_acc = 0;
    int          first_acc_cyc = -1;
    int          first_inst_cyc = -1;
    bit          got_pop = 0;
    logic [31:0] first_pop_pc = 32'hDEAD_BEEF;

    function automatic logic [31:0] idata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] logged(input int i);
        return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic clear_obs();
        n_acc = 0; first_acc_cyc = -1; first_inst_cyc = -1;
        got_pop = 0; first_pop_pc = 32'hDEAD_BEEF;
        acc_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.inst_ready = 0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_inst_data", bus.inst_data, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        chk("rst_fault", 32'(bus.misalign_fault), 0);
        mq.delete(); occ = 0; exp_req_pc = 0; exp_inst_pc = 0; halted = 0;
        clear_obs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive inputs at negedge, check outputs, then advance the model to the next edge.
    task automatic step(input bit redir, input logic [31:0] rpc);
        int stale_n;
        bit acc, pop, rsp_live;
        int lat;
        logic [31:0] tgt;
        @(negedge clk);
        cyc++;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_rsp_valid = 0;
        bus.imem_rsp_data  = 0;
        if (mq.size() > 0 && lat_max > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1;
            bus.imem_rsp_data  = idata(mq[0].addr);
        end
        bus.imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.inst_ready     = (ir_mode == 2) ? 1'($urandom_range(0, 1)) : (ir_mode == 1);
        #1;
        if (!halted) begin
            stale_n = 0;
            foreach (mq[i]) if (mq[i].stale) stale_n++;
            chk("inst_valid", 32'(bus.inst_valid), 32'(occ > 0));
            chk("req_valid", 32'(bus.imem_req_valid),
                32'(!redir && stale_n == 0 && (mq.size() + occ < D)));
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_req_pc);
        end
        if (bus.inst_valid && first_inst_cyc < 0) first_inst_cyc = cyc;
        acc = bus.imem_req_valid & bus.imem_req_ready;
        pop = bus.inst_valid & bus.inst_ready;
        rsp_live = 0;
        if (bus.imem_rsp_valid) begin
            rsp_live = !mq[0].stale;
            void'(mq.pop_front());
        end
        if (pop && !redir && !halted) begin
            if (!got_pop) begin got_pop = 1; first_pop_pc = bus.inst_pc; end
            chk("inst_pc", bus.inst_pc, exp_inst_pc);
            chk("inst_data", bus.inst_data, idata(exp_inst_pc));
            exp_inst_pc += 4;
        end
        if (acc) begin
            if (n_acc == 0) first_acc_cyc = cyc;
            n_acc++;
            acc_log.push_back(bus.imem_req_addr);
            lat = (lat_max > 0) ? $urandom_range(1, lat_max) : 1;
            mq.push_back('{addr: exp_req_pc, due: cyc + lat, stale: 1'b0});
            exp_req_pc += 4;
        end
        if (redir && !halted) begin
            foreach (mq[i]) mq[i].stale = 1;
            occ = 0;
`ifdef FETCH_ALIGN_CHECK_EN
            tgt = rpc;
            if (rpc[1:0] != 2'b00) halted = 1;
`else
            tgt = rpc & 32'hFFFF_FFFC;
`endif
            exp_req_pc = tgt;
            exp_inst_pc = tgt;
        end else if (!redir) begin
            occ = occ + int'(rsp_live) - int'(pop);
        end
    endtask

    initial begin
        logic [31:0] rt;
        bus.redirect_valid = 0; bus.redirect_pc = 0; bus.imem_req_ready = 0;
        bus.imem_rsp_valid = 0; bus.imem_rsp_data = 0; bus.inst_ready = 0;

        // T1: sequential fetch, first instruction two cycles after first accept
        do_reset();
        lat_max = 1; rdy_rand = 0; ir_mode = 1;
        repeat (12) step(0, 0);
        chk("t1_latency", 32'(first_inst_cyc - first_acc_cyc), 2);
        chk("t1_first_pc", first_pop_pc, 32'h0);
        chk("t1_addr1", logged(1), 32'h4);

        // T2: decode stalled -> only IQ_DEPTH requests, then resume after a pop
        do_reset();
        lat_max = 1; ir_mode = 0;
        repeat (10) step(0, 0);
        chk("t2_accepts", 32'(n_acc), 2);
        chk("t2_req_off", 32'(bus.imem_req_valid), 0);
        ir_mode = 1;
        repeat (4) step(0, 0);
        chk("t2_resume", 32'(n_acc > 2), 1);

        // T3: redirect with two outstanding -> both dropped, fetch restarts at 0x100
        do_reset();
        lat_max = 0; ir_mode = 1;
        repeat (4) step(0, 0);
        chk("t3_outstanding", 32'(n_acc), 2);
        clear_obs();
        step(1, 32'h0000_0100);
        lat_max = 1;
        repeat (10) step(0, 0);
        chk("t3_first_addr", logged(0), 32'h100);
        chk("t3_first_pc", first_pop_pc, 32'h100);

        // T4: redirect, pop and response in the same cycle
        do_reset();
        lat_max = 1; ir_mode = 0;
        repeat (2) step(0, 0);
        chk("t4_head_valid", 32'(bus.inst_valid), 0);
        ir_mode = 1;
        step(1, 32'h0000_0200);
        step(0, 0);
        chk("t4_empty", 32'(bus.inst_valid), 0);
        chk("t4_req_valid", 32'(bus.imem_req_valid), 1);
        chk("t4_req_addr", bus.imem_req_addr, 32'h200);
        repeat (6) step(0, 0);

        // T5: fetch address wraps past the top of memory
        do_reset();
        lat_max = 1; ir_mode = 1;
        step(1, 32'hFFFF_FFFC);
        clear_obs();
        repeat (8) step(0, 0);
        chk("t5_top", logged(0), 32'hFFFF_FFFC);
        chk("t5_wrap", logged(1), 32'h0);

        // T6: misaligned redirect target
        do_reset();
        lat_max = 1; ir_mode = 1;
        repeat (3) step(0, 0);
        clear_obs();
        step(1, 32'h0000_0102);
        repeat (6) step(0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_fault", 32'(bus.misalign_fault), 1);
        chk("t6_req_off", 32'(bus.imem_req_valid), 0);
        chk("t6_inst_off", 32'(bus.inst_valid), 0);
        chk("t6_no_accept", 32'(n_acc), 0);
`else
        chk("t6_aligned_addr", logged(0), 32'h100);
        chk("t6_no_fault", 32'(bus.misalign_fault), 0);
`endif

        // Randomized traffic: latency, backpressure, decode stalls, redirects, one mid-run reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                lat_max  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3);
                rdy_rand = 1'($urandom_range(0, 1));
                ir_mode  = $urandom_range(0, 2);
            end
            if (n == 1500) do_reset();
            if ($urandom_range(0, 15) == 0) begin
                rt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
                rt = rt & 32'hFFFF_FFFC;
`endif
                if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF4;
                step(1, rt);
            end else begin
                step(0, 0);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
